muldiv_unit: RTL

Iterative RV32M multiply/divide unit placed in the execute stage beside the ALU of the pipelined core. It executes all eight M-extension operations with a parametrised XLEN and bits-per-cycle throughput. A valid/ready handshake lets the controller stall fetch/decode while the unit is busy. A kill input abandons the in-flight operation on a taken branch or jump flush.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_step.sv | 46 ++++
 rtl/muldiv_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  // func3 encoding of the M-extension operations
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // Divide and remainder share the upper half of the func3 space
  function automatic logic md_is_div(md_op_e op);
    return op[2];
  endfunction

  // rs1 is treated as two's complement
  function automatic logic md_signed_a(md_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as two's complement
  function automatic logic md_signed_b(md_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// Combinational iteration slice: BITS_PER_CYCLE shift-add (multiply) or
// restoring-subtract (divide) steps applied to the packed partial state.
//   multiply: part = {accumulator, remaining multiplier bits}, opnd = multiplicand
//   divide:   part = {partial remainder, dividend/quotient bits}, opnd = divisor
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                is_div,
  input  logic [XLEN-1:0]     opnd,
  input  logic [2*XLEN-1:0]   part_i,
  output logic [2*XLEN-1:0]   part_o
);

  logic [2*XLEN-1:0] p;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     rem_ext;
  logic [XLEN:0]     diff;

  // Unrolled chain of single-bit steps; the carry/borrow bit is kept in the
  // extra MSB of sum/diff so no information is lost between steps.
  always_comb begin
    p       = part_i;
    sum     = '0;
    rem_ext = '0;
    diff    = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div) begin
        rem_ext = {p[2*XLEN-1:XLEN], p[XLEN-1]};
        diff    = rem_ext - {1'b0, opnd};
        if (!diff[XLEN]) begin
          p = {diff[XLEN-1:0], p[XLEN-2:0], 1'b1};
        end else begin
          p = {rem_ext[XLEN-1:0], p[XLEN-2:0], 1'b0};
        end
      end else begin
        sum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        p   = {sum, p[XLEN-1:1]};
      end
    end
    part_o = p;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Handshake: a request transfers on a clock edge where in_valid && in_ready
// && !kill; a result transfers on an edge where out_valid && out_ready && !kill.
// Optional build macro MULDIV_FAST_SPECIAL_EN: divide-by-zero, signed divide
// overflow and multiplies with a zero operand go straight from IDLE to DONE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] opr_a,
  input  logic [XLEN-1:0] opr_b,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  md_op_e            op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic              dz_q, dz_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] part_q, part_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  md_op_e            op_in;
  logic              accept;
  logic              in_div;
  logic              in_sa;
  logic              in_sb;
  logic              in_dz;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              in_fast;
  logic [XLEN-1:0]   fast_result;
  logic [2*XLEN-1:0] step_part;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   final_result;

  // Request decode: sign flags and operand magnitudes
  always_comb begin
    op_in  = md_op_e'(op);
    accept = (state_q == IDLE) && in_valid && !kill;
    in_div = md_is_div(op_in);
    in_sa  = md_signed_a(op_in) & opr_a[XLEN-1];
    in_sb  = md_signed_b(op_in) & opr_b[XLEN-1];
    in_dz  = in_div && (opr_b == '0);
    mag_a  = in_sa ? (~opr_a + 1'b1) : opr_a;
    mag_b  = in_sb ? (~opr_b + 1'b1) : opr_b;
  end

`ifdef MULDIV_FAST_SPECIAL_EN
  logic in_ovf;
  // Early-out detection and its directly computed result
  always_comb begin
    in_ovf      = in_div && md_signed_b(op_in) && (opr_a == MIN) && (opr_b == ONES);
    in_fast     = in_dz || in_ovf || (!in_div && ((opr_a == '0) || (opr_b == '0)));
    fast_result = '0;
    if (in_dz) begin
      fast_result = op_in[1] ? opr_a : ONES;
    end else if (in_ovf) begin
      fast_result = op_in[1] ? '0 : opr_a;
    end
  end
`else
  assign in_fast     = 1'b0;
  assign fast_result = '0;
`endif

  muldiv_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .is_div (md_is_div(op_q)),
    .opnd   (opnd_q),
    .part_i (part_q),
    .part_o (step_part)
  );

  // Sign correction and result selection once the iterations are exhausted.
  // Signed overflow needs no special case: |MIN|/1 = MIN with no negation.
  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? (~part_q + 1'b1) : part_q;
    if (dz_q) begin
      quot_fix = ONES;
    end else begin
      quot_fix = (sign_a_q ^ sign_b_q) ? (~part_q[XLEN-1:0] + 1'b1) : part_q[XLEN-1:0];
    end
    rem_fix = sign_a_q ? (~part_q[2*XLEN-1:XLEN] + 1'b1) : part_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                        final_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               final_result = quot_fix;
      default:                       final_result = rem_fix;
    endcase
  end

  // Next-state logic; kill outranks out_ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = in_fast ? DONE : BUSY;
      BUSY: begin
        if (kill)              state_d = IDLE;
        else if (cnt_q == '0)  state_d = DONE;
      end
      DONE: begin
        if (kill || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath register updates: latch on accept, iterate in BUSY
  always_comb begin
    op_d     = op_q;
    rd_d     = rd_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dz_d     = dz_q;
    opnd_d   = opnd_q;
    part_d   = part_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (accept) begin
      op_d     = op_in;
      rd_d     = rd_in;
      sign_a_d = in_sa;
      sign_b_d = in_sb;
      dz_d     = in_dz;
      opnd_d   = in_div ? mag_b : mag_a;
      part_d   = {{XLEN{1'b0}}, (in_div ? mag_a : mag_b)};
      cnt_d    = CW'(N);
      if (in_fast) result_d = fast_result;
    end else if ((state_q == BUSY) && !kill) begin
      if (cnt_q != '0) begin
        part_d = step_part;
        cnt_d  = cnt_q - CW'(1);
      end else begin
        result_d = final_result;
      end
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      rd_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      opnd_q   <= '0;
      part_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dz_q     <= dz_d;
      opnd_q   <= opnd_d;
      part_q   <= part_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Outputs decoded from the registered state
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    result    = result_q;
    rd_out    = rd_q;
    dbg_state = state_q;
  end

endmodule
